// File: rtl/immgen_pipe_pkg.sv
// Shared RISC-V decode definitions: major opcodes, immediate format enum and
// an XLEN legality helper.
package immgen_pipe_pkg;

   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_OPIMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_Z    = 3'd6
   } imm_type_e;

   function automatic bit xlen_ok(input int unsigned xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/immgen_pipe_if.sv
// Instruction-in / immediate-out stream bundle for immgen_pipe, including the
// decode flush. master drives instructions, slave is the generator.
interface immgen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   import immgen_pipe_pkg::*;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   imm_type_e        out_type;
   logic             out_illeg;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output flush, in_valid, in_instr, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_type, out_illeg, out_tag
   );

   modport slave (
      input  flush, in_valid, in_instr, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_type, out_illeg, out_tag
   );

endinterface

// File: rtl/immgen_pipe_imm_extract.sv
// Combinational immediate extraction: formats the immediate as a signed 32-bit
// value, then sign-extends to XLEN (zimm is positive, so it zero-extends).
module imm_extract
   import immgen_pipe_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit EN_ZICSR = 1'b1
) (
   input  logic [31:0]            instr,
   output logic signed [XLEN-1:0] imm,
   output imm_type_e              imm_type,
   output logic                   illeg
);

   logic signed [31:0] imm32;

   always_comb begin
      imm32    = '0;
      imm_type = IMM_NONE;
      illeg    = 1'b0;
      if (instr[1:0] != 2'b11) begin
         illeg = 1'b1;
      end else begin
         case (instr[6:0])
            OP_OPIMM, OP_LOAD, OP_JALR: begin
               imm_type = IMM_I;
               imm32    = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
               imm_type = IMM_S;
               imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
               imm_type = IMM_B;
               imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
               imm_type = IMM_U;
               imm32    = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
               imm_type = IMM_J;
               imm32    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_SYSTEM: begin
               // funct3[2] selects the immediate CSR forms carrying zimm in rs1
               if (EN_ZICSR && instr[14]) begin
                  imm_type = IMM_Z;
                  imm32    = {27'b0, instr[19:15]};
               end
            end
            OP_OP, OP_MISC_MEM: begin
               imm_type = IMM_NONE;
            end
            default: illeg = 1'b1;
         endcase
      end
   end

   assign imm = XLEN'(imm32);

endmodule

// File: rtl/immgen_pipe.sv
// Registered, handshaked immediate generator: extraction on the input side,
// then a main register plus one skid entry so the block sustains full rate.
module immgen_pipe
   import immgen_pipe_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 32,
   parameter bit EN_ZICSR = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   immgen_pipe_if.slave  bus
);

   logic signed [XLEN-1:0] imm_p0;
   imm_type_e              type_p0;
   logic                   illeg_p0;

   imm_extract #(
      .XLEN     (XLEN),
      .EN_ZICSR (EN_ZICSR)
   ) u_extract (
      .instr    (bus.in_instr),
      .imm      (imm_p0),
      .imm_type (type_p0),
      .illeg    (illeg_p0)
   );

   // ---- stage p0 -> p1: main and skid registers ----
   logic signed [XLEN-1:0] imm_p1, skid_imm_p1;
   imm_type_e              type_p1, skid_type_p1;
   logic                   illeg_p1, skid_illeg_p1;
   logic [TAG_W-1:0]       tag_p1, skid_tag_p1;
   logic                   vld_p1, skid_vld_p1, rdy_p1;

   logic vld_n, skid_vld_n;
   logic main_free, accept;
   logic load_main_in, load_main_skid, load_skid;

   assign main_free = !vld_p1 || bus.out_ready;
   assign accept    = bus.in_valid && rdy_p1 && !bus.flush;

   always_comb begin
      vld_n          = vld_p1;
      skid_vld_n     = skid_vld_p1;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (bus.flush) begin
         vld_n      = 1'b0;
         skid_vld_n = 1'b0;
      end else if (main_free) begin
         // a full skid implies in_ready was low, so no accept competes here
         if (skid_vld_p1) begin
            load_main_skid = 1'b1;
            vld_n          = 1'b1;
            skid_vld_n     = 1'b0;
         end else if (accept) begin
            load_main_in = 1'b1;
            vld_n        = 1'b1;
         end else begin
            vld_n = 1'b0;
         end
      end else if (accept) begin
         load_skid  = 1'b1;
         skid_vld_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         rdy_p1      <= 1'b1;
      end else begin
         vld_p1      <= vld_n;
         skid_vld_p1 <= skid_vld_n;
         rdy_p1      <= !skid_vld_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm_p1   <= '0;
         type_p1  <= IMM_NONE;
         illeg_p1 <= 1'b0;
         tag_p1   <= '0;
      end else if (load_main_skid) begin
         imm_p1   <= skid_imm_p1;
         type_p1  <= skid_type_p1;
         illeg_p1 <= skid_illeg_p1;
         tag_p1   <= skid_tag_p1;
      end else if (load_main_in) begin
         imm_p1   <= imm_p0;
         type_p1  <= type_p0;
         illeg_p1 <= illeg_p0;
         tag_p1   <= bus.in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_imm_p1   <= imm_p0;
         skid_type_p1  <= type_p0;
         skid_illeg_p1 <= illeg_p0;
         skid_tag_p1   <= bus.in_tag;
      end
   end

   assign bus.in_ready  = rdy_p1;
   assign bus.out_valid = vld_p1;
   assign bus.out_imm   = imm_p1;
   assign bus.out_type  = type_p1;
   assign bus.out_illeg = illeg_p1;
   assign bus.out_tag   = tag_p1;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: three instances cover XLEN=32, XLEN=64 and
// the configuration without Zicsr immediates.
module tb_immgen_pipe;
   import immgen_pipe_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   immgen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
   immgen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();
   immgen_pipe_if #(.XLEN(32), .TAG_W(32)) bnz ();

   immgen_pipe #(.XLEN(32), .TAG_W(32), .EN_ZICSR(1'b1)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(b32));
   immgen_pipe #(.XLEN(64), .TAG_W(32), .EN_ZICSR(1'b1)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
   immgen_pipe #(.XLEN(32), .TAG_W(32), .EN_ZICSR(1'b0)) u_dutnz (.clk(clk), .rst_n(rst_n), .bus(bnz));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] tag);
      b32.in_valid = 1'b1;
      b32.in_instr = instr;
      b32.in_tag   = tag;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] imm,
                             input imm_type_e ty, input logic il, input logic [31:0] t);
      chk({tag, ".valid"}, 64'(b32.out_valid), 64'd1);
      chk({tag, ".imm"},   64'(b32.out_imm),   64'(imm));
      chk({tag, ".type"},  64'(b32.out_type),  64'(ty));
      chk({tag, ".illeg"}, 64'(b32.out_illeg), 64'(il));
      chk({tag, ".tag"},   64'(b32.out_tag),   64'(t));
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst_n  = 1'b0;
      b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_tag = '0; b32.out_ready = 1'b0;
      b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_tag = '0; b64.out_ready = 1'b0;
      bnz.flush = 1'b0; bnz.in_valid = 1'b0; bnz.in_instr = '0; bnz.in_tag = '0; bnz.out_ready = 1'b0;
      repeat (2) step();

      chk("rst.valid", 64'(b32.out_valid), 64'd0);
      chk("rst.ready", 64'(b32.in_ready),  64'd1);
      chk("rst.imm",   64'(b32.out_imm),   64'd0);
      chk("rst.type",  64'(b32.out_type),  64'(IMM_NONE));
      chk("rst.illeg", 64'(b32.out_illeg), 64'd0);
      chk("rst.tag",   64'(b32.out_tag),   64'd0);
      rst_n = 1'b1;
      step();

      // addi x1,x0,-1 and a back-to-back branch/jump stream at full rate
      b32.out_ready = 1'b1;
      drive(32'hFFF00093, 32'h100);
      step();
      expect_out("addi", 32'hFFFFFFFF, IMM_I, 1'b0, 32'h100);
      chk("addi.rdy", 64'(b32.in_ready), 64'd1);
      drive(32'h00000463, 32'h104);
      step();
      expect_out("beq", 32'h00000008, IMM_B, 1'b0, 32'h104);
      chk("beq.rdy", 64'(b32.in_ready), 64'd1);
      drive(32'hFFDFF06F, 32'h108);
      step();
      expect_out("jal", 32'hFFFFFFFC, IMM_J, 1'b0, 32'h108);
      chk("jal.rdy", 64'(b32.in_ready), 64'd1);
      drive(32'h0050A423, 32'h10C);
      step();
      expect_out("sw", 32'h00000008, IMM_S, 1'b0, 32'h10C);
      drive(32'h003100B3, 32'h110);
      step();
      expect_out("add", 32'h0, IMM_NONE, 1'b0, 32'h110);
      drive(32'h00000000, 32'h114);
      step();
      expect_out("zero", 32'h0, IMM_NONE, 1'b1, 32'h114);
      drive(32'hFFF00090, 32'h118);
      step();
      expect_out("rvc", 32'h0, IMM_NONE, 1'b1, 32'h118);
      b32.in_valid = 1'b0;
      step();
      chk("idle.valid", 64'(b32.out_valid), 64'd0);

      // backpressure: two accepted, third held until the skid drains
      b32.out_ready = 1'b0;
      drive(32'h00100093, 32'h200);
      step();
      expect_out("bp.a", 32'd1, IMM_I, 1'b0, 32'h200);
      chk("bp.a.rdy", 64'(b32.in_ready), 64'd1);
      drive(32'h00200093, 32'h204);
      step();
      chk("bp.skid.rdy", 64'(b32.in_ready), 64'd0);
      expect_out("bp.hold", 32'd1, IMM_I, 1'b0, 32'h200);
      drive(32'h00300093, 32'h208);
      step();
      chk("bp.full.rdy", 64'(b32.in_ready), 64'd0);
      expect_out("bp.hold2", 32'd1, IMM_I, 1'b0, 32'h200);
      b32.out_ready = 1'b1;
      step();
      expect_out("bp.b", 32'd2, IMM_I, 1'b0, 32'h204);
      chk("bp.b.rdy", 64'(b32.in_ready), 64'd1);
      step();
      expect_out("bp.c", 32'd3, IMM_I, 1'b0, 32'h208);
      b32.in_valid = 1'b0;
      step();
      chk("bp.end.valid", 64'(b32.out_valid), 64'd0);

      // flush with both entries occupied
      b32.out_ready = 1'b0;
      drive(32'h00100093, 32'h300);
      step();
      drive(32'h00200093, 32'h304);
      step();
      chk("fl.pre.rdy", 64'(b32.in_ready), 64'd0);
      b32.in_valid = 1'b0;
      b32.flush    = 1'b1;
      step();
      chk("fl.valid", 64'(b32.out_valid), 64'd0);
      chk("fl.rdy",   64'(b32.in_ready),  64'd1);
      drive(32'h00500093, 32'h308);
      step();
      chk("fl.drop.valid", 64'(b32.out_valid), 64'd0);
      b32.flush     = 1'b0;
      b32.out_ready = 1'b1;
      drive(32'h00600093, 32'h30C);
      step();
      expect_out("fl.new", 32'd6, IMM_I, 1'b0, 32'h30C);
      b32.in_valid = 1'b0;

      // wider datapath and Zicsr-disabled configuration
      b64.out_ready = 1'b1;
      bnz.out_ready = 1'b1;
      b64.in_valid  = 1'b1;
      b64.in_instr  = 32'h800000B7;
      b64.in_tag    = 32'h400;
      bnz.in_valid  = 1'b1;
      bnz.in_instr  = 32'h000FD073;
      bnz.in_tag    = 32'h404;
      step();
      chk("x64.lui.valid", 64'(b64.out_valid), 64'd1);
      chk("x64.lui.imm",   b64.out_imm,        64'hFFFFFFFF80000000);
      chk("x64.lui.type",  64'(b64.out_type),  64'(IMM_U));
      chk("nz.csr.valid",  64'(bnz.out_valid), 64'd1);
      chk("nz.csr.imm",    64'(bnz.out_imm),   64'd0);
      chk("nz.csr.type",   64'(bnz.out_type),  64'(IMM_NONE));
      chk("nz.csr.illeg",  64'(bnz.out_illeg), 64'd0);
      b64.in_instr = 32'h000FD073;
      bnz.in_valid = 1'b0;
      step();
      chk("x64.csr.imm",   b64.out_imm,        64'h1F);
      chk("x64.csr.type",  64'(b64.out_type),  64'(IMM_Z));
      chk("x64.csr.illeg", 64'(b64.out_illeg), 64'd0);
      b64.in_valid = 1'b0;

      // asynchronous reset while holding valid data
      b32.out_ready = 1'b0;
      drive(32'hFFF00093, 32'h500);
      step();
      drive(32'h00200093, 32'h504);
      step();
      chk("ar.pre.valid", 64'(b32.out_valid), 64'd1);
      chk("ar.pre.rdy",   64'(b32.in_ready),  64'd0);
      b32.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.valid", 64'(b32.out_valid), 64'd0);
      chk("ar.imm",   64'(b32.out_imm),   64'd0);
      chk("ar.tag",   64'(b32.out_tag),   64'd0);
      chk("ar.type",  64'(b32.out_type),  64'(IMM_NONE));
      chk("ar.rdy",   64'(b32.in_ready),  64'd1);
      step();
      rst_n = 1'b1;
      step();
      chk("ar.post.valid", 64'(b32.out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
